// File: rtl/reorder_tag_arbiter_if.sv
// Requester / issue / retire bundle for the reorder tag arbiter.
// The arbiter sits on the slave side; the requesters, downstream issue
// consumer and FIFO retire source together form the master side.
interface reorder_tag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int AWID  = $clog2(DEPTH),
  parameter int SWID  = $clog2(NREQ)
);
  logic                softreset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic                issue_vld;
  logic [AWID:0]       issue_tag;
  logic [SWID-1:0]     issue_src;
  logic                issue_ready;
  logic                retire;
  logic [AWID:0]       outstanding;
  logic                idle;
  logic                err;

  modport master (
    output softreset, req, issue_ready, retire,
    input  gnt, issue_vld, issue_tag, issue_src, outstanding, idle, err
  );

  modport slave (
    input  softreset, req, issue_ready, retire,
    output gnt, issue_vld, issue_tag, issue_src, outstanding, idle, err
  );
endinterface

// File: rtl/reorder_tag_arbiter.sv
// Round-robin requester arbiter that stamps each grant with a sequence tag
// for a reordering FIFO. Tags run 0..2*DEPTH-1 so the FIFO can tell full
// from empty; a credit count of unretired tags caps work in flight at DEPTH.
module reorder_tag_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int AWID  = $clog2(DEPTH),
  parameter int SWID  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reorder_tag_arbiter_if.slave  bus
);

  localparam logic [AWID:0]   TAG_LAST = (AWID+1)'(2*DEPTH-1);
  localparam logic [AWID:0]   CRED_MAX = (AWID+1)'(DEPTH);
  localparam logic [SWID-1:0] SRC_LAST = SWID'(NREQ-1);

  logic [SWID-1:0] ptr_q;
  logic [AWID:0]   tag_cnt_q;
  logic [AWID:0]   out_cnt_q;
  logic            vld_q;
  logic [AWID:0]   tag_q;
  logic [SWID-1:0] src_q;
  logic            err_q;

  logic            slot_free;
  logic            credit_ok;
  logic            can_grant;
  logic            win_vld;
  logic [SWID-1:0] win;
  logic [SWID-1:0] ptr_nxt;
  logic [AWID:0]   tag_nxt;
  logic            ret_eff;
  logic            ret_bad;
  logic [NREQ-1:0] gnt;

  // Slot frees up when empty or being drained this cycle; credits are
  // judged on the registered count only, so a retire never bypasses.
  always_comb begin
    slot_free = !vld_q || bus.issue_ready;
    credit_ok = out_cnt_q < CRED_MAX;
    can_grant = rst_n && !bus.softreset && slot_free && credit_ok && (|bus.req);
  end

  // Round-robin search: p, p+1, .., NREQ-1, 0, .., p-1; first asserted wins.
  always_comb begin
    int              idx;
    logic [SWID-1:0] idx_w;
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = SWID'(idx);
      if (!win_vld && bus.req[idx_w]) begin
        win_vld = 1'b1;
        win     = idx_w;
      end
    end
  end

  // One-hot grant pulse, only in a cycle where a grant is actually taken.
  always_comb begin
    gnt = '0;
    if (can_grant && win_vld) gnt[win] = 1'b1;
  end

  // Pointer and tag successors; both wrap explicitly since neither range
  // need be a power of two.
  always_comb begin
    ptr_nxt = (win == SRC_LAST) ? '0 : win + 1'b1;
    tag_nxt = (tag_cnt_q == TAG_LAST) ? '0 : tag_cnt_q + 1'b1;
    ret_eff = bus.retire && (out_cnt_q != '0);
    ret_bad = bus.retire && (out_cnt_q == '0);
  end

  // Arbitration pointer and tag counter advance on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      tag_cnt_q <= '0;
    end else if (bus.softreset) begin
      ptr_q     <= '0;
      tag_cnt_q <= '0;
    end else if (can_grant) begin
      ptr_q     <= ptr_nxt;
      tag_cnt_q <= tag_nxt;
    end
  end

  // Issue slot: load on grant, hold under backpressure, drain on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      tag_q <= '0;
      src_q <= '0;
    end else if (bus.softreset) begin
      vld_q <= 1'b0;
      tag_q <= '0;
      src_q <= '0;
    end else if (can_grant) begin
      vld_q <= 1'b1;
      tag_q <= tag_cnt_q;
      src_q <= win;
    end else if (bus.issue_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Credit count: grant adds, effective retire subtracts, both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
    end else if (bus.softreset) begin
      out_cnt_q <= '0;
    end else begin
      case ({can_grant, ret_eff})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // Sticky flag for a retire arriving with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_q <= 1'b0;
    else if (bus.softreset)  err_q <= 1'b0;
    else if (ret_bad)        err_q <= 1'b1;
  end

  assign bus.gnt         = gnt;
  assign bus.issue_vld   = vld_q;
  assign bus.issue_tag   = tag_q;
  assign bus.issue_src   = src_q;
  assign bus.outstanding = out_cnt_q;
  assign bus.idle        = (out_cnt_q == '0) && !vld_q;
  assign bus.err         = err_q;

  // Credit ceiling and grant shape invariants.
  a_credit_cap: assert property (@(posedge clk) disable iff (!rst_n)
    out_cnt_q <= CRED_MAX);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

endmodule

// File: tb/tb_reorder_tag_arbiter.sv
// Scoreboard bench: a behavioural model predicts grants each cycle and
// queues the expected tag/source for the issue slot; the slot contents are
// compared against the queue head while valid.
module tb_reorder_tag_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int AWID  = $clog2(DEPTH);
  localparam int SWID  = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reorder_tag_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus ();
  reorder_tag_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_ptr, m_tag, m_out;
  bit m_vld, m_err;
  int q_tag[$];
  int q_src[$];

  task automatic chk(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", t, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_tag = 0; m_out = 0; m_vld = 0; m_err = 0;
    q_tag.delete(); q_src.delete();
  endtask

  // One clock: compare at negedge, advance model at posedge, return at +1.
  task automatic step();
    logic [NREQ-1:0] eg;
    bit g, re;
    int w;
    @(negedge clk);
    eg = '0; g = 0; w = 0;
    if (!bus.softreset && (!m_vld || bus.issue_ready) && m_out < DEPTH && (|bus.req)) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!g && bus.req[i]) begin g = 1; w = i; end
      end
      eg[w] = 1'b1;
    end
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("issue_vld", 32'(bus.issue_vld), 32'(m_vld));
    if (m_vld && q_tag.size() > 0) begin
      chk("issue_tag", 32'(bus.issue_tag), q_tag[0]);
      chk("issue_src", 32'(bus.issue_src), q_src[0]);
    end
    chk("outstanding", 32'(bus.outstanding), m_out);
    chk("err", 32'(bus.err), 32'(m_err));
    chk("idle", 32'(bus.idle), 32'(m_out == 0 && !m_vld));
    @(posedge clk);
    if (bus.softreset) begin
      model_reset();
    end else begin
      re = bus.retire && m_out > 0;
      if (bus.retire && m_out == 0) m_err = 1;
      if (m_vld && bus.issue_ready) begin
        void'(q_tag.pop_front());
        void'(q_src.pop_front());
        m_vld = 0;
      end
      if (g) begin
        q_tag.push_back(m_tag);
        q_src.push_back(w);
        m_vld = 1;
        m_tag = (m_tag + 1) % (2*DEPTH);
        m_ptr = (w + 1) % NREQ;
      end
      m_out = m_out + (g ? 1 : 0) - (re ? 1 : 0);
    end
    #1;
  endtask

  task automatic check_reset_vals(input string t);
    chk({t, "_gnt"},  32'(bus.gnt), 0);
    chk({t, "_vld"},  32'(bus.issue_vld), 0);
    chk({t, "_tag"},  32'(bus.issue_tag), 0);
    chk({t, "_src"},  32'(bus.issue_src), 0);
    chk({t, "_out"},  32'(bus.outstanding), 0);
    chk({t, "_err"},  32'(bus.err), 0);
    chk({t, "_idle"}, 32'(bus.idle), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.softreset = 1'b0; bus.req = '0; bus.issue_ready = 1'b0; bus.retire = 1'b0;
    model_reset();
    #12;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single requester fills all credits, then one retire frees one grant
    bus.req = 4'b0001; bus.issue_ready = 1'b1;
    repeat (10) step();
    chk("full_out", 32'(bus.outstanding), DEPTH);
    bus.retire = 1'b1; step(); bus.retire = 1'b0;
    step(); step();

    // drain credits, then an extra retire trips the sticky error
    bus.req = '0; bus.retire = 1'b1;
    repeat (11) step();
    bus.retire = 1'b0; step();
    chk("err_set", 32'(bus.err), 1);
    chk("err_out0", 32'(bus.outstanding), 0);
    bus.softreset = 1'b1; step(); bus.softreset = 1'b0; step();
    chk("err_clr", 32'(bus.err), 0);

    // round-robin with retire every cycle; long enough to wrap the tag
    bus.req = 4'b1111; bus.retire = 1'b1;
    repeat (24) step();
    bus.req = '0;
    for (int n = 0; n < 20 && m_out > 0; n++) step();
    bus.retire = 1'b0;
    bus.softreset = 1'b1; step(); bus.softreset = 1'b0;

    // backpressure holds the slot, release grants in the same cycle
    bus.req = 4'b0001; bus.issue_ready = 1'b1; step();
    bus.issue_ready = 1'b0; repeat (4) step();
    bus.issue_ready = 1'b1; step();
    bus.req = '0; step(); step();

    // random traffic, occasional softreset
    bus.softreset = 1'b1; step(); bus.softreset = 1'b0;
    repeat (400) begin
      bus.req         = NREQ'($urandom);
      bus.issue_ready = ($urandom % 4) != 0;
      bus.retire      = ($urandom % 3) == 0;
      bus.softreset   = ($urandom % 97) == 0;
      step();
    end
    bus.softreset = 1'b1; bus.retire = 1'b0; step(); bus.softreset = 1'b0;

    // async reset mid-stream with outstanding=5 and a valid slot
    bus.req = 4'b0001; bus.issue_ready = 1'b1;
    repeat (5) step();
    chk("pre_rst_out", 32'(bus.outstanding), 5);
    chk("pre_rst_vld", 32'(bus.issue_vld), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    model_reset();
    @(posedge clk); #1;
    bus.req = 4'b0110;
    rst_n = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
